// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage, the instruction memory port and the
// decode-stage pipeline registers.
interface fetch_unit_if;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        load_de_npc;
  logic        load_de_ir;
  logic [15:0] fetch_npc;
  logic [15:0] fetch_ir;

  modport master (
    output imem_read, imem_address, load_de_npc, load_de_ir, fetch_npc, fetch_ir,
    input  imem_rdata, imem_resp, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_read, imem_address, load_de_npc, load_de_ir, fetch_npc, fetch_ir,
    output imem_rdata, imem_resp, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// LC-3b instruction-fetch stage: owns the PC, reads instruction memory and
// loads decode NPC/IR, with stall buffering and redirect/squash handling.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_IR   = 16'h0000
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {START, FETCH, HOLD, SQUASH} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [15:0] r_target, w_target_nxt;
  logic [15:0] r_npc_buf, w_npc_buf_nxt;
  logic [15:0] r_ir_buf, w_ir_buf_nxt;
  logic [15:0] w_pc_inc;

  logic        w_imem_read;
  logic        w_load;
  logic [15:0] w_fetch_npc;
  logic [15:0] w_fetch_ir;

  assign w_pc_inc = r_pc + 16'd2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= START;
      r_pc      <= RESET_PC;
      r_target  <= 16'h0000;
      r_npc_buf <= 16'h0000;
      r_ir_buf  <= 16'h0000;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_target  <= w_target_nxt;
      r_npc_buf <= w_npc_buf_nxt;
      r_ir_buf  <= w_ir_buf_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_target_nxt  = r_target;
    w_npc_buf_nxt = r_npc_buf;
    w_ir_buf_nxt  = r_ir_buf;
    w_imem_read   = 1'b0;
    w_load        = 1'b0;
    w_fetch_npc   = r_npc_buf;
    w_fetch_ir    = r_ir_buf;

    // A redirect always flushes decode with a NOP, even under stall.
    if (bus.redirect && r_state != START) begin
      w_load      = 1'b1;
      w_fetch_npc = bus.redirect_pc;
      w_fetch_ir  = NOP_IR;
    end

    unique case (r_state)
      START: w_state_nxt = FETCH;

      FETCH: begin
        w_imem_read = 1'b1;
        if (bus.redirect) begin
          if (bus.imem_resp) w_pc_nxt = bus.redirect_pc;
          else begin
            w_target_nxt = bus.redirect_pc;
            w_state_nxt  = SQUASH;
          end
        end else if (bus.imem_resp && !bus.stall) begin
          w_load      = 1'b1;
          w_fetch_npc = w_pc_inc;
          w_fetch_ir  = bus.imem_rdata;
          w_pc_nxt    = w_pc_inc;
        end else if (bus.imem_resp) begin
          w_npc_buf_nxt = w_pc_inc;
          w_ir_buf_nxt  = bus.imem_rdata;
          w_pc_nxt      = w_pc_inc;
          w_state_nxt   = HOLD;
        end
      end

      HOLD: begin
        if (bus.redirect) begin
          w_pc_nxt    = bus.redirect_pc;
          w_state_nxt = FETCH;
        end else if (!bus.stall) begin
          w_load      = 1'b1;
          w_state_nxt = FETCH;
        end
      end

      SQUASH: begin
        // The stale request stays on the bus until memory answers it.
        w_imem_read = 1'b1;
        if (bus.redirect) w_target_nxt = bus.redirect_pc;
        if (bus.imem_resp) begin
          w_pc_nxt    = bus.redirect ? bus.redirect_pc : r_target;
          w_state_nxt = FETCH;
        end
      end

      default: w_state_nxt = START;
    endcase
  end

  assign bus.imem_read    = w_imem_read;
  assign bus.imem_address = r_pc;
  assign bus.load_de_npc  = w_load;
  assign bus.load_de_ir   = w_load;
  assign bus.fetch_npc    = w_fetch_npc;
  assign bus.fetch_ir     = w_fetch_ir;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: decode loads are scoreboarded, bus-side
// outputs are checked at each step, plus a PC-wrap instance.
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] npc;
    logic [15:0] ir;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic reset_n2 = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  fetch_unit_if bus1 ();
  fetch_unit_if bus2 ();

  fetch_unit #(.RESET_PC(16'h0000), .NOP_IR(16'h0000)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  fetch_unit #(.RESET_PC(16'hFFFE), .NOP_IR(16'h0000)) dut2 (
    .clk(clk), .reset_n(reset_n2), .bus(bus2)
  );

  // Zero-wait memory for the wrap instance.
  assign bus2.imem_resp   = bus2.imem_read;
  assign bus2.imem_rdata  = 16'h7777;
  assign bus2.stall       = 1'b0;
  assign bus2.redirect    = 1'b0;
  assign bus2.redirect_pc = 16'h0000;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] npc, input logic [15:0] ir);
    q.push_back('{npc: npc, ir: ir});
  endtask

  // Scoreboard: every decode load must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    chk("load_pair", {15'd0, bus1.load_de_npc}, {15'd0, bus1.load_de_ir});
    if (bus1.load_de_ir) begin
      if (q.size() == 0) chk("unexpected_load", 16'd1, 16'd0);
      else begin
        e = q.pop_front();
        chk("load_npc", bus1.fetch_npc, e.npc);
        chk("load_ir", bus1.fetch_ir, e.ir);
      end
    end
  end

  initial begin
    bus1.imem_resp = 1'b0; bus1.imem_rdata = 16'h0000;
    bus1.stall = 1'b0; bus1.redirect = 1'b0; bus1.redirect_pc = 16'h0000;

    // Reset held with clock running
    repeat (2) @(negedge clk);
    chk("rst_read", {15'd0, bus1.imem_read}, 16'd0);
    chk("rst_load", {15'd0, bus1.load_de_ir}, 16'd0);
    chk("rst_npc", bus1.fetch_npc, 16'h0000);
    chk("rst_ir", bus1.fetch_ir, 16'h0000);
    step();
    reset_n = 1'b1;

    // START
    @(negedge clk); chk("start_read", {15'd0, bus1.imem_read}, 16'd0);
    step();

    // Zero-wait stream
    bus1.imem_resp = 1'b1; bus1.imem_rdata = 16'h1234; push(16'h0002, 16'h1234);
    @(negedge clk); chk("f0_read", {15'd0, bus1.imem_read}, 16'd1); chk("f0_addr", bus1.imem_address, 16'h0000);
    step();
    bus1.imem_rdata = 16'h5678; push(16'h0004, 16'h5678);
    @(negedge clk); chk("f1_addr", bus1.imem_address, 16'h0002);
    step();
    bus1.imem_rdata = 16'h9ABC; push(16'h0006, 16'h9ABC);
    @(negedge clk); chk("f2_addr", bus1.imem_address, 16'h0004);
    step();

    // Stall: response arrives while decode is stalled, held 3 cycles
    bus1.imem_rdata = 16'hABCD; bus1.stall = 1'b1;
    @(negedge clk); chk("st_addr", bus1.imem_address, 16'h0006);
    step();
    bus1.imem_resp = 1'b0;
    @(negedge clk); chk("hold_read0", {15'd0, bus1.imem_read}, 16'd0);
    step();
    @(negedge clk); chk("hold_read1", {15'd0, bus1.imem_read}, 16'd0);
    step();
    bus1.stall = 1'b0; push(16'h0008, 16'hABCD);
    @(negedge clk); chk("hold_read2", {15'd0, bus1.imem_read}, 16'd0);
    step();

    // Redirect with a request outstanding (2-cycle memory)
    bus1.redirect = 1'b1; bus1.redirect_pc = 16'h3000; push(16'h3000, 16'h0000);
    @(negedge clk); chk("rd_read", {15'd0, bus1.imem_read}, 16'd1); chk("rd_addr", bus1.imem_address, 16'h0008);
    step();
    bus1.redirect = 1'b0; bus1.imem_resp = 1'b1; bus1.imem_rdata = 16'hDEAD;
    @(negedge clk); chk("sq_read", {15'd0, bus1.imem_read}, 16'd1); chk("sq_addr", bus1.imem_address, 16'h0008);
    step();

    // Redirect plus stall in HOLD
    bus1.imem_rdata = 16'h1111; bus1.stall = 1'b1;
    @(negedge clk); chk("tgt_addr", bus1.imem_address, 16'h3000);
    step();
    bus1.imem_resp = 1'b0; bus1.redirect = 1'b1; bus1.redirect_pc = 16'h4000; push(16'h4000, 16'h0000);
    @(negedge clk); chk("hr_read", {15'd0, bus1.imem_read}, 16'd0);
    step();

    // Redirect, then a second redirect while squashing
    bus1.stall = 1'b0; bus1.redirect_pc = 16'h5000; push(16'h5000, 16'h0000);
    @(negedge clk); chk("hr_addr", bus1.imem_address, 16'h4000); chk("hr_read1", {15'd0, bus1.imem_read}, 16'd1);
    step();
    bus1.redirect_pc = 16'h6000; push(16'h6000, 16'h0000);
    @(negedge clk); chk("sq2_addr", bus1.imem_address, 16'h4000);
    step();
    bus1.redirect = 1'b0;
    @(negedge clk); chk("sq3_read", {15'd0, bus1.imem_read}, 16'd1);
    step();

    // Async reset during SQUASH, between clock edges
    #2 reset_n = 1'b0;
    #1;
    chk("arst_read", {15'd0, bus1.imem_read}, 16'd0);
    chk("arst_load", {15'd0, bus1.load_de_ir}, 16'd0);
    chk("arst_npc", bus1.fetch_npc, 16'h0000);
    chk("arst_ir", bus1.fetch_ir, 16'h0000);
    step();
    reset_n = 1'b1;
    // Late response lands in START and must be ignored
    bus1.imem_resp = 1'b1; bus1.imem_rdata = 16'hBEEF;
    @(negedge clk); chk("late_read", {15'd0, bus1.imem_read}, 16'd0);
    step();
    bus1.imem_resp = 1'b0;
    @(negedge clk); chk("late_addr", bus1.imem_address, 16'h0000); chk("late_read1", {15'd0, bus1.imem_read}, 16'd1);
    step();

    // PC wrap from RESET_PC=FFFE
    reset_n2 = 1'b1;
    @(negedge clk); chk("w_start", {15'd0, bus2.imem_read}, 16'd0);
    step();
    @(negedge clk);
    chk("w_addr0", bus2.imem_address, 16'hFFFE);
    chk("w_load", {15'd0, bus2.load_de_ir}, 16'd1);
    chk("w_npc", bus2.fetch_npc, 16'h0000);
    chk("w_ir", bus2.fetch_ir, 16'h7777);
    step();
    @(negedge clk); chk("w_addr1", bus2.imem_address, 16'h0000);

    chk("sb_empty", 16'(q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
